// File: rtl/core_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_scheduler_pkg: shared state encodings for the core control path.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package core_scheduler_pkg;

    localparam int PC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_e;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'd0,
        FETCHER_FETCHING = 3'd1,
        FETCHER_FETCHED  = 3'd2
    } fetcher_state_e;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/core_scheduler_lsu_wait_reduce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_wait_reduce: flags when no enabled lane has a memory op outstanding. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_wait_reduce
    import core_scheduler_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0]   thread_enable,
    output logic                           all_lsu_idle_or_done
);

    always_comb begin
        all_lsu_idle_or_done = 1'b1;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] &&
                (lsu_state[2*i +: 2] == LSU_REQUESTING || lsu_state[2*i +: 2] == LSU_WAITING))
                all_lsu_idle_or_done = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_scheduler: per-core FETCH..UPDATE sequencer and current_pc owner.   |
// | Optional WAIT abort counter: SCHED_WAIT_TIMEOUT_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module core_scheduler
    import core_scheduler_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_W              = PC_W_DEFAULT,
    parameter int WAIT_TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [THREADS_PER_BLOCK-1:0]   thread_enable,
    input  logic [2:0]                     fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state,
    input  logic                           decoded_ret,
    input  logic [PC_W*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                     core_state,
    output logic [PC_W-1:0]                current_pc,
    output logic                           done,
    output logic                           wait_timeout
);

    core_state_e     r_state;
    logic            w_lsu_clear;
    logic [PC_W-1:0] w_sel_pc;

    lsu_wait_reduce #(
        .THREADS_PER_BLOCK(THREADS_PER_BLOCK)
    ) u_lsu_wait_reduce (
        .lsu_state            (lsu_state),
        .thread_enable        (thread_enable),
        .all_lsu_idle_or_done (w_lsu_clear)
    );

    // Lanes are convergent, so the lowest enabled lane speaks for the block.
    always_comb begin
        w_sel_pc = next_pc[PC_W-1:0];
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
            if (thread_enable[i])
                w_sel_pc = next_pc[PC_W*i +: PC_W];
        end
    end

`ifdef SCHED_WAIT_TIMEOUT_EN
    localparam logic [7:0] c_wait_last = 8'(WAIT_TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
    logic       r_wait_timeout;
    assign wait_timeout = r_wait_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^WAIT_TIMEOUT;
    assign wait_timeout = 1'b0;
`endif

    assign core_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= CORE_IDLE;
            current_pc <= '0;
            done       <= 1'b0;
`ifdef SCHED_WAIT_TIMEOUT_EN
            r_wait_cnt     <= 8'd0;
            r_wait_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                CORE_IDLE: begin
                    if (start) begin
                        if (thread_enable != '0) begin
                            r_state <= CORE_FETCH;
                        end else begin
                            r_state <= CORE_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                CORE_FETCH: begin
                    if (fetcher_state == FETCHER_FETCHED)
                        r_state <= CORE_DECODE;
                end
                CORE_DECODE:  r_state <= CORE_REQUEST;
                CORE_REQUEST: begin
                    r_state <= CORE_WAIT;
`ifdef SCHED_WAIT_TIMEOUT_EN
                    r_wait_cnt <= 8'd0;
`endif
                end
                CORE_WAIT: begin
                    // Completion takes priority over the abort limit.
                    if (w_lsu_clear) begin
                        r_state <= CORE_EXECUTE;
                    end
`ifdef SCHED_WAIT_TIMEOUT_EN
                    else if (r_wait_cnt == c_wait_last) begin
                        r_state        <= CORE_DONE;
                        done           <= 1'b1;
                        r_wait_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
`endif
                end
                CORE_EXECUTE: r_state <= CORE_UPDATE;
                CORE_UPDATE: begin
                    if (decoded_ret) begin
                        r_state <= CORE_DONE;
                        done    <= 1'b1;
                    end else begin
                        current_pc <= w_sel_pc;
                        r_state    <= CORE_FETCH;
                    end
                end
                default: begin
                    r_state <= CORE_DONE;
                    done    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_scheduler: directed self-checking bench for core_scheduler.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_core_scheduler;

`ifdef SCHED_WAIT_TIMEOUT_EN
    localparam int TB_WAIT_TIMEOUT = 8;
`else
    localparam int TB_WAIT_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thread_enable;
    logic [2:0]  fetcher_state;
    logic [7:0]  lsu_state;
    logic        decoded_ret;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done;
    logic        wait_timeout;

    int n_pass  = 0;
    int n_total = 0;

    core_scheduler #(
        .THREADS_PER_BLOCK(4),
        .PC_W(8),
        .WAIT_TIMEOUT(TB_WAIT_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_enable (thread_enable),
        .fetcher_state (fetcher_state),
        .lsu_state     (lsu_state),
        .decoded_ret   (decoded_ret),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .wait_timeout  (wait_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        start         = 1'b0;
        thread_enable = 4'b0000;
        fetcher_state = 3'd0;
        lsu_state     = 8'h00;
        decoded_ret   = 1'b0;
        next_pc       = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({core_state, current_pc, done, wait_timeout} !== {3'd0, 8'h00, 1'b0, 1'b0})
            $display("FAIL reset_init: state=%0d pc=%h done=%b wto=%b, want 0/00/0/0",
                     core_state, current_pc, done, wait_timeout);
        else n_pass++;
        // Drive into WAIT with busy LSUs, then reset mid-instruction.
        thread_enable = 4'b1111;
        fetcher_state = 3'd2;
        lsu_state     = 8'b10_10_10_10;
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        n_total++;
        if (core_state !== 3'd4)
            $display("FAIL reset_reach_wait: state=%0d want 4", core_state);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++;
        if ({core_state, current_pc, done} !== {3'd0, 8'h00, 1'b0})
            $display("FAIL reset_mid_wait: state=%0d pc=%h done=%b, want 0/00/0",
                     core_state, current_pc, done);
        else n_pass++;
    endtask

    task automatic test_basic_sequence();
        logic [2:0] exp_seq [8];
        exp_seq = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
        do_reset();
        thread_enable = 4'b1111;
        fetcher_state = 3'd1;
        next_pc       = {8'h01, 8'h01, 8'h01, 8'h01};
        start         = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            if (i == 1) fetcher_state = 3'd2;
            n_total++;
            if (core_state !== exp_seq[i])
                $display("FAIL basic_state[%0d]: state=%0d want %0d", i, core_state, exp_seq[i]);
            else n_pass++;
            if (i == 6) begin
                n_total++;
                if (current_pc !== 8'h00)
                    $display("FAIL basic_pc_before_update: pc=%h want 00", current_pc);
                else n_pass++;
            end
        end
        n_total++;
        if (current_pc !== 8'h01)
            $display("FAIL basic_pc_after_update: pc=%h want 01", current_pc);
        else n_pass++;
    endtask

    // Continues from FETCH left by test_basic_sequence.
    task automatic test_lsu_wait();
        thread_enable = 4'b0111;
        fetcher_state = 3'd2;
        next_pc       = {8'h05, 8'h05, 8'h05, 8'h05};
        lsu_state     = 8'b10_00_00_00;
        step();
        step();
        n_total++;
        if (core_state !== 3'd3)
            $display("FAIL lsu_request: state=%0d want 3", core_state);
        else n_pass++;
        lsu_state = 8'b10_01_00_00;
        step();
        lsu_state = 8'b10_10_00_00;
        for (int k = 1; k <= 4; k++) begin
            n_total++;
            if (core_state !== 3'd4)
                $display("FAIL lsu_wait_cycle%0d: state=%0d want 4", k, core_state);
            else n_pass++;
            step();
        end
        n_total++;
        if (core_state !== 3'd4)
            $display("FAIL lsu_wait_cycle5: state=%0d want 4", core_state);
        else n_pass++;
        lsu_state = 8'b10_11_00_00;
        step();
        n_total++;
        if (core_state !== 3'd5)
            $display("FAIL lsu_exec_after_wait: state=%0d want 5", core_state);
        else n_pass++;
        step();
        step();
        n_total++;
        if ({core_state, current_pc} !== {3'd1, 8'h05})
            $display("FAIL lsu_update_pc: state=%0d pc=%h want 1/05", core_state, current_pc);
        else n_pass++;
        lsu_state = 8'h00;
    endtask

    task automatic test_lowest_lane();
        logic [3:0] en_tab [2];
        logic [7:0] pc_tab [2];
        en_tab = '{4'b0110, 4'b1100};
        pc_tab = '{8'h10, 8'h20};
        next_pc = {8'h30, 8'h20, 8'h10, 8'h00};
        fetcher_state = 3'd2;
        for (int t = 0; t < 2; t++) begin
            thread_enable = en_tab[t];
            repeat (6) step();
            n_total++;
            if ({core_state, current_pc} !== {3'd1, pc_tab[t]})
                $display("FAIL lowest_lane[%0d]: state=%0d pc=%h want 1/%h",
                         t, core_state, current_pc, pc_tab[t]);
            else n_pass++;
        end
    endtask

    task automatic test_ret_and_done();
        thread_enable = 4'b1111;
        fetcher_state = 3'd2;
        next_pc       = {8'h07, 8'h07, 8'h07, 8'h07};
        repeat (6) step();
        n_total++;
        if (current_pc !== 8'h07)
            $display("FAIL ret_setup_pc: pc=%h want 07", current_pc);
        else n_pass++;
        next_pc     = {8'h09, 8'h09, 8'h09, 8'h09};
        decoded_ret = 1'b1;
        repeat (6) step();
        n_total++;
        if ({core_state, done, current_pc} !== {3'd7, 1'b1, 8'h07})
            $display("FAIL ret_done: state=%0d done=%b pc=%h want 7/1/07",
                     core_state, done, current_pc);
        else n_pass++;
        decoded_ret = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step();
        end
        n_total++;
        if ({core_state, done, current_pc} !== {3'd7, 1'b1, 8'h07})
            $display("FAIL done_sticky: state=%0d done=%b pc=%h want 7/1/07",
                     core_state, done, current_pc);
        else n_pass++;
    endtask

    task automatic test_empty_block();
        do_reset();
        thread_enable = 4'b0000;
        start         = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({core_state, done} !== {3'd7, 1'b1})
            $display("FAIL empty_block: state=%0d done=%b want 7/1", core_state, done);
        else n_pass++;
    endtask

    task automatic enter_wait_busy();
        do_reset();
        thread_enable = 4'b1111;
        fetcher_state = 3'd2;
        lsu_state     = 8'b10_10_10_10;
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_wait_timeout();
        enter_wait_busy();
`ifdef SCHED_WAIT_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            step();
            n_total++;
            if ({core_state, wait_timeout} !== {3'd4, 1'b0})
                $display("FAIL timeout_hold[%0d]: state=%0d wto=%b want 4/0", k, core_state, wait_timeout);
            else n_pass++;
        end
        step();
        n_total++;
        if ({core_state, done, wait_timeout} !== {3'd7, 1'b1, 1'b1})
            $display("FAIL timeout_abort: state=%0d done=%b wto=%b want 7/1/1",
                     core_state, done, wait_timeout);
        else n_pass++;
        // Completion in the limit cycle wins over the abort.
        enter_wait_busy();
        repeat (7) step();
        lsu_state = 8'h00;
        step();
        n_total++;
        if ({core_state, wait_timeout} !== {3'd5, 1'b0})
            $display("FAIL timeout_completion_wins: state=%0d wto=%b want 5/0", core_state, wait_timeout);
        else n_pass++;
`else
        repeat (20) step();
        n_total++;
        if ({core_state, done, wait_timeout} !== {3'd4, 1'b0, 1'b0})
            $display("FAIL wait_forever: state=%0d done=%b wto=%b want 4/0/0",
                     core_state, done, wait_timeout);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_lsu_wait();
        test_lowest_lane();
        test_ret_and_done();
        test_empty_block();
        test_wait_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_scheduler.md
Name: core_scheduler

Overview:
Per-core control FSM that sequences one instruction at a time through the core: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
- Drives the 3-bit core_state bus. The per-thread pc blocks, fetcher, decoder, ALUs and LSUs key off this bus.
- Owns the core's single current_pc register.
- Advances the FSM when the fetcher and all enabled LSUs report completion.
- Latches the per-thread next_pc back into current_pc.

Parameters:
THREADS_PER_BLOCK, 4, number of thread lanes (pc/LSU instances) in the core.
PC_W, 8, program-counter width.
WAIT_TIMEOUT, 255, max cycles in WAIT before abort (used only with optional feature).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
start  in  1  block dispatch pulse/level from dispatcher
thread_enable  in  THREADS_PER_BLOCK  1 = lane active for this block
fetcher_state  in  3  fetcher FSM state (IDLE/FETCHING/FETCHED)
lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU state (IDLE/REQUESTING/WAITING/DONE), lane i at [2i+1:2i]
decoded_ret  in  1  decoder flag: current instruction is RET
next_pc  in  PC_W*THREADS_PER_BLOCK  per-lane next PC from pc blocks, lane i at [PC_W*i +: PC_W]
core_state  out  3  current core state
current_pc  out  PC_W  PC of instruction in flight
done  out  1  block complete (sticky until reset)
wait_timeout  out  1  sticky WAIT-timeout flag (0 when feature compiled out)

Behaviour:
- All state changes occur on posedge clk.
- Reset is synchronous, active-high, and has priority over everything, including mid-instruction. Reset values: core_state=IDLE, current_pc=0, done=0, wait_timeout=0.
- Encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.

FSM transitions:
- IDLE: if start and thread_enable!=0 -> FETCH. If start and thread_enable==0 -> DONE, done<=1. Otherwise hold.
- FETCH: hold until fetcher_state==FETCHED, then -> DECODE.
- DECODE: exactly 1 cycle -> REQUEST.
- REQUEST: exactly 1 cycle -> WAIT. LSUs of memory instructions leave IDLE on this edge.
- WAIT: minimum 1 cycle. -> EXECUTE in the first cycle where no enabled lane has lsu_state REQUESTING or WAITING. Disabled lanes' lsu_state is ignored.
- EXECUTE: exactly 1 cycle -> UPDATE. The pc blocks compute next_pc on this edge, so next_pc is valid throughout UPDATE.
- UPDATE: if decoded_ret -> DONE, done<=1, current_pc unchanged. Else current_pc <= next_pc of the lowest-indexed enabled lane, -> FETCH. Lanes are assumed convergent; other lanes' next_pc is ignored.
- DONE: terminal. Holds with done=1, ignores start, leaves only on reset.

Other rules:
- current_pc changes only in UPDATE. Wrap-around is inherited from next_pc (0xFF+1 = 0x00); the scheduler performs no arithmetic on the PC.
- Instruction latency with zero-wait fetch and no memory op: FETCH(>=1) + DECODE + REQUEST + WAIT + EXECUTE + UPDATE = 6 cycles minimum.
- start asserted outside IDLE has no effect.
- thread_enable is sampled continuously; it must be stable from start until done. Changes mid-block are undefined.

Optional Feature:
Macro SCHED_WAIT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on WAIT entry and increments each cycle in WAIT.
  - When it reaches WAIT_TIMEOUT with LSUs still busy: -> DONE, done<=1, wait_timeout<=1 (sticky until reset).
  - If LSUs complete in the same cycle the limit is reached, completion wins: -> EXECUTE, no flag.
- Undefined: no counter; WAIT may hold forever; wait_timeout tied to 0.

Decomposition:
- Shared defines/package holds:
  - CORE_* state encodings (CORE_EXECUTE etc., as used by pc)
  - FETCHER_* and LSU_* state encodings
  - PC_W default
- One natural sub-module: lsu_wait_reduce. Combinational reduction of lsu_state and thread_enable into an all_lsu_idle_or_done flag.
- The FSM and PC register stay in core_scheduler.

Test Plan:
1. Reset mid-WAIT with LSUs busy -> next cycle core_state=0, current_pc=0x00, done=0.
2. start, thread_enable=4'b1111, FETCHED after 2 cycles, no memory op, next_pc all 0x01 -> state sequence 1,1,2,3,4,5,6,1. current_pc=0x01 after UPDATE.
3. Memory instruction: lane 2 lsu_state WAITING for 5 cycles after REQUEST, lane 3 disabled and stuck WAITING -> exactly 5 WAIT cycles, then EXECUTE. Lane 3 ignored.
4. thread_enable=4'b0110, next_pc lanes = {0x30,0x20,0x10,0x00} (lane3..0) -> current_pc<=0x10 (lane 1).
5. decoded_ret=1 in UPDATE at current_pc=0x07 -> core_state=7, done=1, current_pc stays 0x07. Later start pulses cause no change.
6. With SCHED_WAIT_TIMEOUT_EN and WAIT_TIMEOUT=8, LSU never completes -> DONE after 8 WAIT cycles, wait_timeout=1. Without the macro, FSM stays in WAIT and wait_timeout=0.
